// File: rtl/ccff_loader_pkg.sv
// Shared FSM encoding and sizing helper for the configuration-chain loader.
package ccff_loader_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        LOAD = 2'd1,
        DONE = 2'd2
    } state_e;

    // The bit counter must be able to hold CHAIN_LEN itself, not just CHAIN_LEN-1.
    function automatic int cnt_width(input int chain_len);
        return $clog2(chain_len + 1);
    endfunction

endpackage

// File: rtl/ccff_readback_sipo.sv
// Serial-to-parallel readback: packs sampled chain tail bits into words, bit 0 oldest.
// A flush emits whatever has been gathered, zero-padded in the upper bits.
module ccff_readback_sipo #(
    parameter int WORD_W = 8
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              sample,
    input  logic              tail,
    input  logic              flush,
    output logic [WORD_W-1:0] rd_data,
    output logic              rd_valid
);

    localparam int IW = (WORD_W > 1) ? $clog2(WORD_W) : 1;

    logic [WORD_W-1:0] shreg;
    logic [WORD_W-1:0] merged;
    logic [IW-1:0]     idx;
    logic              emit;

    always_comb begin
        merged = shreg;
        if (sample) merged = shreg | (WORD_W'(tail) << idx);
    end

    assign emit = (sample && (idx == IW'(WORD_W - 1))) ||
                  (flush && (sample || (idx != '0)));

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            shreg    <= '0;
            idx      <= '0;
            rd_data  <= '0;
            rd_valid <= 1'b0;
        end else begin
            rd_valid <= emit;
            if (emit) begin
                rd_data <= merged;
                shreg   <= '0;
                idx     <= '0;
            end else if (sample) begin
                shreg <= merged;
                idx   <= idx + 1'b1;
            end
        end
    end

endmodule

// File: rtl/ccff_chain_loader.sv
// Streams bitstream words serially into a configuration flip-flop chain while
// capturing the chain's previous contents from its tail as readback words.
module ccff_chain_loader
    import ccff_loader_pkg::*;
#(
    parameter int CHAIN_LEN = 4096,
    parameter int WORD_W    = 8
) (
    input  logic              prog_clk,
    input  logic              pReset,
    input  logic              start,
    input  logic [WORD_W-1:0] s_data,
    input  logic              s_valid,
    output logic              s_ready,
    output logic              ccff_head,
    output logic              ccff_shift_en,
    input  logic              ccff_tail,
    output logic [WORD_W-1:0] rd_data,
    output logic              rd_valid,
    output logic              busy,
    output logic              done
);

    localparam int CW = cnt_width(CHAIN_LEN);
    localparam int BW = $clog2(WORD_W + 1);
    localparam logic [CW-1:0] LAST = CW'(CHAIN_LEN - 1);

    state_e            state, state_nxt;
    logic [CW-1:0]     bit_cnt;
    logic [WORD_W-1:0] word_buf;
    logic [BW-1:0]     buf_bits;
    logic              last_shift;
    logic              take;
    logic              go;

    assign ccff_shift_en = (state == LOAD) && (buf_bits != '0);
    assign last_shift    = ccff_shift_en && (bit_cnt == LAST);
    assign take          = s_valid && s_ready;
    assign go            = start && (state != LOAD);

    always_ff @(posedge prog_clk or posedge pReset) begin
        if (pReset) state <= IDLE;
        else        state <= state_nxt;
    end

    always_comb begin
        state_nxt = state;
        case (state)
            IDLE, DONE: if (start) state_nxt = LOAD;
            LOAD:       if (last_shift) state_nxt = DONE;
            default:    state_nxt = IDLE;
        endcase
    end

    // A word may land on the same edge the last buffered bit leaves, but never
    // when that bit completes the chain: it would only be thrown away.
    always_comb begin
        s_ready   = 1'b0;
        busy      = 1'b0;
        done      = 1'b0;
        ccff_head = ccff_shift_en & word_buf[0];
        case (state)
            LOAD: begin
                busy    = 1'b1;
                s_ready = (buf_bits == '0) || ((buf_bits == BW'(1)) && !last_shift);
            end
            DONE:    done = 1'b1;
            default: ;
        endcase
    end

    always_ff @(posedge prog_clk or posedge pReset) begin
        if (pReset) begin
            bit_cnt  <= '0;
            word_buf <= '0;
            buf_bits <= '0;
        end else begin
            if (go)                 bit_cnt <= '0;
            else if (ccff_shift_en) bit_cnt <= bit_cnt + 1'b1;

            if (last_shift) begin
                word_buf <= '0;
                buf_bits <= '0;
            end else if (take) begin
                word_buf <= s_data;
                buf_bits <= BW'(WORD_W);
            end else if (ccff_shift_en) begin
                word_buf <= word_buf >> 1;
                buf_bits <= buf_bits - 1'b1;
            end
        end
    end

    ccff_readback_sipo #(.WORD_W(WORD_W)) u_sipo (
        .clk      (prog_clk),
        .rst      (pReset),
        .sample   (ccff_shift_en),
        .tail     (ccff_tail),
        .flush    (last_shift),
        .rd_data  (rd_data),
        .rd_valid (rd_valid)
    );

endmodule

// File: tb/tb_ccff_chain_loader.sv
// Two loader instances (16-bit and 12-bit chains) each driving a behavioural chain;
// expected head bits and readback words are queued at load start and popped by a monitor.
module tb_ccff_chain_loader;

    localparam int W = 8;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    int total = 0;
    int bad   = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    for (genvar g = 0; g < 2; g++) begin : lane
        localparam int CL = (g == 0) ? 16 : 12;
        localparam int NW = (CL + W - 1) / W;

        logic          prst = 1'b1;
        logic          start = 1'b0;
        logic          s_valid = 1'b0;
        logic [W-1:0]  s_data = '0;
        logic          s_ready, head, shift_en, tail, rd_valid, busy, done;
        logic [W-1:0]  rd_data;
        logic [CL-1:0] chain = '0;
        logic          preload_req = 1'b0;
        bit            hq[$];
        logic [W-1:0]  rq[$];
        int            load_cnt = 0;
        bit            prev_shift = 1'b0;
        bit            fin = 1'b0;

        assign tail = chain[CL-1];

        ccff_chain_loader #(.CHAIN_LEN(CL), .WORD_W(W)) dut (
            .prog_clk      (clk),
            .pReset        (prst),
            .start         (start),
            .s_data        (s_data),
            .s_valid       (s_valid),
            .s_ready       (s_ready),
            .ccff_head     (head),
            .ccff_shift_en (shift_en),
            .ccff_tail     (tail),
            .rd_data       (rd_data),
            .rd_valid      (rd_valid),
            .busy          (busy),
            .done          (done)
        );

        // Physical chain: shifts toward the tail on enabled edges.
        always @(posedge clk) begin
            if (preload_req)   chain <= '1;
            else if (shift_en) chain <= {chain[CL-2:0], head};
        end

        // Monitor: pops expected head bits and readback words as the DUT presents them.
        always @(negedge clk) begin
            if (start && !busy) load_cnt = 0;
            if (prev_shift) check("done timing", done, (load_cnt == CL));
            if (shift_en) begin
                load_cnt++;
                if (hq.size() == 0) check("unexpected shift", 1, 0);
                else                check("ccff_head", head, hq.pop_front());
            end
            if (rd_valid) begin
                if (rq.size() == 0) check("unexpected rd_valid", 1, 0);
                else                check("rd_data", rd_data, rq.pop_front());
            end
            prev_shift = shift_en;
        end

        initial begin
            logic [W-1:0]  wq[$];
            logic [CL-1:0] expc;
            logic [W-1:0]  r;
            int            wi, cycles, gapcnt, starve;
            bit            xfer, gap, aborted, spam;

            repeat (2) @(negedge clk);
            check("reset outputs", {s_ready, head, shift_en, rd_valid, busy, done, rd_data}, 0);
            @(posedge clk); #1 prst = 1'b0;

            for (int t = 0; t < 12; t++) begin
                wq.delete();
                for (int i = 0; i <= NW; i++) wq.push_back(W'($urandom));
                if (t < 2) begin
                    wq[0] = (CL == 16) ? 8'hA5 : 8'hFF;
                    wq[1] = (CL == 16) ? 8'h3C : 8'h0F;
                end
                if (t == 0) begin
                    @(posedge clk); #1 preload_req = 1'b1;
                    @(posedge clk); #1 preload_req = 1'b0;
                end
                // Reference: first CL stream bits land head-first; tail yields old contents in order.
                for (int j = 0; j < CL; j++) begin
                    hq.push_back(wq[j / W][j % W]);
                    expc[CL-1-j] = wq[j / W][j % W];
                end
                for (int w = 0; w < NW; w++) begin
                    r = '0;
                    for (int k = 0; k < W; k++)
                        if (w * W + k < CL) r[k] = chain[CL-1-(w * W + k)];
                    rq.push_back(r);
                end

                spam = (t == 3) || (t >= 6 && $urandom_range(0, 1) == 1);
                @(posedge clk); #1;
                start   = 1'b1;
                s_valid = (t >= 6) ? 1'($urandom_range(0, 1)) : 1'b0;
                s_data  = wq[0];
                @(negedge clk);
                check("s_ready at start", s_ready, 0);
                @(posedge clk); #1 start = 1'b0;

                wi = 0; cycles = 0; gapcnt = 0; starve = 0; aborted = 1'b0;
                while (!done && !aborted && cycles < 200) begin
                    if (t == 2)      gap = (wi == 1) && (gapcnt < 12);
                    else if (t >= 6) gap = ($urandom_range(0, 3) == 0);
                    else             gap = 1'b0;
                    if (gap) gapcnt++;
                    s_valid = (wi < wq.size()) && !gap;
                    s_data  = (wi < wq.size()) ? wq[wi] : '0;
                    start   = spam ? 1'($urandom_range(0, 1)) : 1'b0;
                    @(negedge clk); #1;
                    xfer = s_valid && s_ready;
                    if (busy && !shift_en) starve++;
                    if (t == 4 && load_cnt >= 6) begin
                        #2 prst = 1'b1;
                        #1 check("async reset outputs",
                                 {s_ready, head, shift_en, rd_valid, busy, done, rd_data}, 0);
                        aborted = 1'b1;
                    end
                    @(posedge clk); #1;
                    if (xfer) wi++;
                    cycles++;
                end
                start = 1'b0;

                if (aborted) begin
                    s_valid = 1'b0;
                    hq.delete();
                    rq.delete();
                    repeat (2) @(posedge clk);
                    #1 prst = 1'b0;
                    repeat (3) @(negedge clk);
                    check("idle after reset", {busy, done, shift_en, rd_valid}, 0);
                end else begin
                    s_valid = 1'b1;
                    s_data  = 8'h55;
                    @(negedge clk); #1;
                    check("load completes", done, 1);
                    check("s_ready in DONE", s_ready, 0);
                    check("shift count", load_cnt, CL);
                    check("chain contents", chain, expc);
                    check("head bits pending", hq.size(), 0);
                    check("readback pending", rq.size(), 0);
                    if (t < 4) check("starved cycles", starve, (t == 2) ? 6 : 1);
                    s_valid = 1'b0;
                end
            end
            fin = 1'b1;
        end
    end

    initial begin
        #300000;
        $display("FAIL watchdog: bench did not finish, lanes=%0d%0d expected 11", lane[0].fin, lane[1].fin);
        $fatal(1, "timeout");
    end

    initial begin
        wait (lane[0].fin && lane[1].fin);
        repeat (2) @(negedge clk);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
